// File: rtl/nist_block_freq.sv
// nist_block_freq: NIST SP800-22 Frequency Test within a Block, streaming monitor.
// The serial bit stream is cut into blocks of M = 2^LOG2_M bits, and N = 2^LOG2_N
// blocks make one sequence. For each sequence the block accumulates the sum of
// (ones - M/2)^2 and flags the sequence as failed when that sum reaches LIMIT.
// Every W = 2^LOG2_W sequences form a window, and a sticky error is raised when a
// window holds more than MAX_FAIL failed sequences.
module nist_block_freq #(
  parameter int LOG2_M   = 4,
  parameter int LOG2_N   = 3,
  parameter int LIMIT    = 81,
  parameter int LOG2_W   = 7,
  parameter int MAX_FAIL = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         rnd_valid,
  input  logic                         rnd_in,
  output logic                         seq_done,
  output logic                         seq_fail,
  output logic [LOG2_N+2*LOG2_M-2:0]   sigma_out,
  output logic [LOG2_W:0]              fail_cnt,
  output logic                         win_done,
  output logic [LOG2_W:0]              win_fails,
  output logic                         error
);

  // Width of the sigma accumulator. It can hold N * M^2/4 without overflowing.
  localparam int SW = LOG2_N + 2 * LOG2_M - 1;
  // Working width for the squaring and summing logic. It is wide enough for every
  // intermediate value, and synthesis removes the constant-zero upper bits.
  localparam int PW = SW + 2 * LOG2_M + 2;

  localparam logic [LOG2_M-1:0] BIT_LAST = '1;
  localparam logic [LOG2_N-1:0] BLK_LAST = '1;
  localparam logic [LOG2_W-1:0] SEQ_LAST = '1;
  localparam logic [LOG2_M:0]   HALF     = {2'b01, {(LOG2_M - 1){1'b0}}};
  localparam logic [PW-1:0]     LIMIT_V  = PW'(LIMIT);
  localparam logic [LOG2_W+1:0] MAX_V    = (LOG2_W + 2)'(MAX_FAIL);

  // rst and clr have the same effect, and both override every other update.
  logic srst;
  assign srst = rst | clr;

  // Stage 1 state: position inside the current block and the running ones count.
  logic [LOG2_M-1:0] bit_cnt;
  logic [LOG2_M:0]   ones;
  logic [LOG2_M:0]   c_q;
  logic              blk_v_q;

  // Stage 2 state: block index inside the sequence and the partial sigma.
  logic [LOG2_N-1:0] blk_cnt;
  logic [SW-1:0]     sigma;

  // Window state: number of sequences seen in the current window.
  logic [LOG2_W-1:0] seq_cnt;

  logic [LOG2_M:0]   dev;
  logic [PW-1:0]     sq;
  logic [PW-1:0]     sum;
  logic [LOG2_W:0]   nf;

  // Stage 1: count accepted bits and ones, and hand each finished block count to stage 2.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. Every flop then samples
    // pre-edge values, whatever order the statements are written in.
    if (srst) begin
      bit_cnt <= '0;
      ones    <= '0;
      c_q     <= '0;
      blk_v_q <= 1'b0;
    end else begin
      blk_v_q <= 1'b0;
      if (rnd_valid) begin
        if (bit_cnt == BIT_LAST) begin
          c_q     <= ones + {{LOG2_M{1'b0}}, rnd_in};
          blk_v_q <= 1'b1;
          bit_cnt <= '0;
          ones    <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          ones    <= ones + {{LOG2_M{1'b0}}, rnd_in};
        end
      end
    end
  end

  // Stage 2 combinational part: |c - M/2|, its square, and the new running sum.
  always_comb begin
    // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
    dev = (c_q >= HALF) ? (c_q - HALF) : (HALF - c_q);
    sq  = PW'(dev) * PW'(dev);
    sum = PW'(sigma) + sq;
    nf  = fail_cnt + {{LOG2_W{1'b0}}, seq_fail};
  end

  // Stage 2: accumulate sigma, and publish the result on the last block of a sequence.
  always_ff @(posedge clk) begin
    if (srst) begin
      blk_cnt   <= '0;
      sigma     <= '0;
      seq_done  <= 1'b0;
      seq_fail  <= 1'b0;
      sigma_out <= '0;
    end else begin
      seq_done <= 1'b0;
      if (blk_v_q) begin
        blk_cnt <= blk_cnt + 1'b1;
        if (blk_cnt == BLK_LAST) begin
          sigma     <= '0;
          sigma_out <= sum[SW-1:0];
          seq_fail  <= (sum >= LIMIT_V);
          seq_done  <= 1'b1;
        end else begin
          sigma <= sum[SW-1:0];
        end
      end
    end
  end

  // Window: count failed sequences, close the window every W sequences, and latch the sticky error.
  always_ff @(posedge clk) begin
    if (srst) begin
      seq_cnt   <= '0;
      fail_cnt  <= '0;
      win_fails <= '0;
      win_done  <= 1'b0;
      error     <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (seq_done) begin
        seq_cnt <= seq_cnt + 1'b1;
        if ({1'b0, nf} > MAX_V) begin
          error <= 1'b1;
        end
        if (seq_cnt == SEQ_LAST) begin
          win_fails <= nf;
          fail_cnt  <= '0;
          win_done  <= 1'b1;
        end else begin
          fail_cnt <= nf;
        end
      end
    end
  end

endmodule

// File: tb/tb_nist_block_freq.sv
// tb_nist_block_freq: scenario-driven bench for nist_block_freq with default parameters.
// The bench uses M=16, N=8, W=128, LIMIT=81 and MAX_FAIL=5. A bit-level model runs
// inside the driver. It pushes the expected sequence and window results, and a
// negedge monitor pops and compares them when the DUT pulses seq_done or win_done.
module tb_nist_block_freq;

  localparam int M        = 16;
  localparam int N        = 8;
  localparam int W        = 128;
  localparam int LIMIT    = 81;
  localparam int MAX_FAIL = 5;
  localparam int SW       = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          rnd_valid = 1'b0;
  logic          rnd_in = 1'b0;
  logic          seq_done;
  logic          seq_fail;
  logic [SW-1:0] sigma_out;
  logic [7:0]    fail_cnt;
  logic          win_done;
  logic [7:0]    win_fails;
  logic          error;

  nist_block_freq dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .rnd_valid (rnd_valid),
    .rnd_in    (rnd_in),
    .seq_done  (seq_done),
    .seq_fail  (seq_fail),
    .sigma_out (sigma_out),
    .fail_cnt  (fail_cnt),
    .win_done  (win_done),
    .win_fails (win_fails),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SW-1:0] sigma;
    logic          fail;
    int            due;
  } seq_exp_t;

  typedef struct {
    logic [7:0] fails;
    int         due;
  } win_exp_t;

  seq_exp_t seq_q[$];
  win_exp_t win_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_bits, m_ones, m_blk, m_sigma, m_wseq, m_fcnt;

  task automatic model_clear();
    m_bits = 0; m_ones = 0; m_blk = 0; m_sigma = 0; m_wseq = 0; m_fcnt = 0;
    seq_q.delete();
    win_q.delete();
  endtask

  // Drive one cycle of input, then advance the model if the bit was accepted.
  task automatic send_bit(input logic v, input logic b);
    seq_exp_t e;
    win_exp_t w;
    rnd_valid = v;
    rnd_in    = b;
    @(posedge clk);
    #1;
    if (v) begin
      m_ones += int'(b);
      m_bits++;
      if (m_bits == M) begin
        m_sigma += (m_ones - M / 2) * (m_ones - M / 2);
        m_bits = 0;
        m_ones = 0;
        m_blk++;
        if (m_blk == N) begin
          e.sigma = m_sigma[SW-1:0];
          e.fail  = (m_sigma >= LIMIT);
          e.due   = cyc + 1;
          seq_q.push_back(e);
          m_wseq++;
          if (e.fail) m_fcnt++;
          if (m_wseq == W) begin
            w.fails = m_fcnt[7:0];
            w.due   = cyc + 2;
            win_q.push_back(w);
            m_wseq = 0;
            m_fcnt = 0;
          end
          m_blk   = 0;
          m_sigma = 0;
        end
      end
    end
  endtask

  task automatic idle();
    send_bit(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_block(input int c);
    for (int i = 0; i < M; i++) send_bit(1'b1, (i < c));
  endtask

  task automatic send_zero_seq();
    for (int i = 0; i < M * N; i++) send_bit(1'b1, 1'b0);
  endtask

  task automatic send_alt_seq();
    for (int i = 0; i < M * N; i++) send_bit(1'b1, 1'(i % 2));
  endtask

  // One-cycle rst or clr, held while a valid 1 is presented, to show reset priority.
  task automatic apply_reset(input bit use_clr);
    if (use_clr) clr = 1'b1; else rst = 1'b1;
    rnd_valid = 1'b1;
    rnd_in    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr = 1'b0;
    rnd_valid = 1'b0;
    model_clear();
  endtask

  task automatic expect_drained(input string name);
    repeat (4) idle();
    checks++;
    if (seq_q.size() != 0 || win_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain: pending seq=%0d win=%0d, required 0/0", name, seq_q.size(), win_q.size());
    end
  endtask

  // Scoreboard monitor: compare each result pulse against the oldest expectation.
  seq_exp_t mon_e;
  win_exp_t mon_w;
  always @(negedge clk) begin
    if (seq_done) begin
      checks++;
      if (seq_q.size() == 0) begin
        failures++;
        $display("FAIL seq_done unexpected at cycle %0d", cyc);
      end else begin
        mon_e = seq_q.pop_front();
        if (sigma_out !== mon_e.sigma || seq_fail !== mon_e.fail || cyc != mon_e.due) begin
          failures++;
          $display("FAIL seq_result: sigma=%0d fail=%b cycle=%0d, required sigma=%0d fail=%b cycle=%0d",
                   sigma_out, seq_fail, cyc, mon_e.sigma, mon_e.fail, mon_e.due);
        end
      end
    end
    if (win_done) begin
      checks++;
      if (win_q.size() == 0) begin
        failures++;
        $display("FAIL win_done unexpected at cycle %0d", cyc);
      end else begin
        mon_w = win_q.pop_front();
        if (win_fails !== mon_w.fails || cyc != mon_w.due) begin
          failures++;
          $display("FAIL win_result: win_fails=%0d cycle=%0d, required win_fails=%0d cycle=%0d",
                   win_fails, cyc, mon_w.fails, mon_w.due);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    checks++;
    if ({seq_done, seq_fail, sigma_out, fail_cnt, win_done, win_fails, error} !== '0) begin
      failures++;
      $display("FAIL reset_state: outputs=%h, required 0",
               {seq_done, seq_fail, sigma_out, fail_cnt, win_done, win_fails, error});
    end
  endtask

  task automatic test_alternating();
    send_alt_seq();
    expect_drained("alternating");
    checks++;
    if (fail_cnt !== 8'd0) begin
      failures++;
      $display("FAIL alt_fail_cnt: got %0d, required 0", fail_cnt);
    end
  endtask

  task automatic test_zeros();
    send_zero_seq();
    expect_drained("zeros");
    checks++;
    if (fail_cnt !== 8'd1) begin
      failures++;
      $display("FAIL zeros_fail_cnt: got %0d, required 1", fail_cnt);
    end
  endtask

  task automatic test_threshold();
    // The first sequence gives sigma 5*16 = 80, which passes. The second has one
    // c=8 block changed to c=9, so sigma is 81 and the sequence fails.
    for (int b = 0; b < N; b++) send_block(b < 5 ? 12 : 8);
    for (int b = 0; b < N; b++) send_block(b < 5 ? 12 : (b == 7 ? 9 : 8));
    expect_drained("threshold");
    checks++;
    if (fail_cnt !== 8'd2) begin
      failures++;
      $display("FAIL threshold_fail_cnt: got %0d, required 2", fail_cnt);
    end
  endtask

  task automatic test_window_error();
    apply_reset(1'b0);
    for (int s = 0; s < 6; s++) send_zero_seq();
    idle();
    checks++;
    if (seq_done !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL err_before: seq_done=%b error=%b, required 1/0", seq_done, error);
    end
    idle();
    checks++;
    if (error !== 1'b1 || fail_cnt !== 8'd6) begin
      failures++;
      $display("FAIL err_rise: error=%b fail_cnt=%0d, required 1/6", error, fail_cnt);
    end
    for (int s = 0; s < W - 6; s++) send_alt_seq();
    expect_drained("window_error");
    checks++;
    if (fail_cnt !== 8'd0 || error !== 1'b1 || win_fails !== 8'd6) begin
      failures++;
      $display("FAIL win_error_end: fail_cnt=%0d error=%b win_fails=%0d, required 0/1/6",
               fail_cnt, error, win_fails);
    end
  endtask

  task automatic test_window_tolerated();
    apply_reset(1'b0);
    for (int s = 0; s < MAX_FAIL; s++) send_zero_seq();
    for (int s = 0; s < W - MAX_FAIL; s++) send_alt_seq();
    expect_drained("window_ok");
    checks++;
    if (error !== 1'b0 || win_fails !== 8'd5 || fail_cnt !== 8'd0) begin
      failures++;
      $display("FAIL win_ok_end: error=%b win_fails=%0d fail_cnt=%0d, required 0/5/0",
               error, win_fails, fail_cnt);
    end
  endtask

  task automatic test_restart(input bit use_clr);
    for (int i = 0; i < 70; i++) send_bit(1'b1, 1'b0);
    apply_reset(use_clr);
    checks++;
    if ({seq_done, seq_fail, sigma_out, fail_cnt, win_done, win_fails, error} !== '0) begin
      failures++;
      $display("FAIL restart_clear(clr=%0d): outputs=%h, required 0", use_clr,
               {seq_done, seq_fail, sigma_out, fail_cnt, win_done, win_fails, error});
    end
    send_zero_seq();
    expect_drained("restart");
    checks++;
    if (fail_cnt !== 8'd1 || error !== 1'b0) begin
      failures++;
      $display("FAIL restart_seq(clr=%0d): fail_cnt=%0d error=%b, required 1/0",
               use_clr, fail_cnt, error);
    end
  endtask

  task automatic test_bubbles();
    int acc;
    apply_reset(1'b0);
    acc = 0;
    while (acc < M * N) begin
      if ($urandom_range(0, 1) == 1) begin
        send_bit(1'b1, 1'b0);
        acc++;
      end else begin
        send_bit(1'b0, 1'b1);
      end
    end
    acc = 0;
    while (acc < M * N) begin
      if ($urandom_range(0, 1) == 1) begin
        send_bit(1'b1, 1'(acc % 2));
        acc++;
      end else begin
        idle();
      end
    end
    expect_drained("bubbles");
    checks++;
    if (fail_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bubbles_fail_cnt: got %0d, required 1", fail_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_alternating();
    test_zeros();
    test_threshold();
    test_window_error();
    test_restart(1'b1);
    test_window_tolerated();
    test_restart(1'b0);
    test_bubbles();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
